// File: rtl/mem_responder.sv
// mem_responder: multi-cycle single-port 16-bit data memory behind a
// request/stall/done handshake. A legal request is accepted in IDLE,
// Stall is held for LATENCY-1 cycles and Done pulses for one cycle.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   Addr    - byte address (bit 0 must be 0), word index Addr[DEPTH_LOG2:1]
//   DataIn  - write data, sampled at acceptance
//   Rd, Wr  - read / write request (exactly one may be high)
//   DataOut - read data, valid with Done, held until the next read completes
//   Stall   - request accepted and still in progress
//   Done    - one-cycle completion pulse
//   err     - one-cycle pulse for each cycle an illegal request is seen in IDLE
//
// LATENCY legal range is 2..15 (the down-counter is 4 bits wide).

module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        err
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Counter starts at LATENCY-2 so that BUSY lasts LATENCY-1 cycles:
  // the last BUSY cycle is the one where the count reads zero.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [15:0]           r_wdata;
  logic                  r_is_wr;
  logic [15:0]           r_mem [WORDS];
  logic [15:0]           r_dout;
  logic                  r_err;

  logic                  w_req;
  logic                  w_legal;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_finish;
  logic                  w_stall;
  logic                  w_done;

  // Address bits above the word index are deliberately dropped (wrap).
  generate
    if (DEPTH_LOG2 < 15) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^Addr[15:DEPTH_LOG2+1];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Request qualification (only meaningful in IDLE)
  // ------------------------------------------------------------------
  assign w_req     = Rd | Wr;
  assign w_legal   = (Rd ^ Wr) & ~Addr[0];
  assign w_accept  = (r_state == S_IDLE) & w_legal;
  assign w_illegal = (r_state == S_IDLE) & w_req & ~w_legal;

  // The edge that leaves BUSY is the one that performs the access.
  assign w_finish  = (r_state == S_BUSY) & (r_cnt == 4'd0);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      // Unconditional: a request still held during DONE is not re-accepted
      // here, which gives the one idle cycle between completions.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs, decoded from the state register only
  // ------------------------------------------------------------------
  always_comb begin
    w_stall = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_BUSY:  w_stall = 1'b1;
      S_DONE:  w_done  = 1'b1;
      default: begin
        w_stall = 1'b0;
        w_done  = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Latency down-counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ------------------------------------------------------------------
  // Request capture
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_wdata <= 16'h0000;
      r_is_wr <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= Addr[DEPTH_LOG2:1];
      r_wdata <= DataIn;
      r_is_wr <= Wr;
    end
  end

  // ------------------------------------------------------------------
  // Storage array. Not reset; a write only fires on the BUSY->DONE edge,
  // so a reset during BUSY forces IDLE and the write never happens.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_finish && r_is_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // ------------------------------------------------------------------
  // Read data register: only updated by a completing read, so writes
  // and illegal requests leave it untouched.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= 16'h0000;
    end else if (w_finish && !r_is_wr) begin
      r_dout <= r_mem[r_idx];
    end
  end

  // ------------------------------------------------------------------
  // Error pulse: one cycle per edge that samples an illegal IDLE request
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_illegal;
    end
  end

  assign DataOut = r_dout;
  assign Stall   = w_stall;
  assign Done    = w_done;
  assign err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
// (DEPTH_LOG2=10, LATENCY=4). Inputs change on the falling edge, outputs
// are sampled on the falling edge; every check goes through chk().

module tb_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = 16'h0000;
  logic [15:0] DataIn = 16'h0000;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Stall;
  logic        Done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(
    .DEPTH_LOG2(10),
    .LATENCY   (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Addr   (Addr),
    .DataIn (DataIn),
    .Rd     (Rd),
    .Wr     (Wr),
    .DataOut(DataOut),
    .Stall  (Stall),
    .Done   (Done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one legal request from a falling edge, release it after acceptance,
  // and check the full Stall/Done timeline plus the following idle cycle.
  task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input logic [15:0] exp_dout,
                         input string tag);
    Rd = rd; Wr = wr; Addr = addr; DataIn = data;
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c < LAT) begin
        chk({tag, "_stall_busy"}, 16'(Stall), 16'd1);
        chk({tag, "_done_busy"},  16'(Done),  16'd0);
      end else begin
        chk({tag, "_stall_done"}, 16'(Stall), 16'd0);
        chk({tag, "_done"},       16'(Done),  16'd1);
        chk({tag, "_dout"},       DataOut,    exp_dout);
      end
    end
    @(negedge clk);
    chk({tag, "_idle_stall"}, 16'(Stall), 16'd0);
    chk({tag, "_idle_done"},  16'(Done),  16'd0);
  endtask

  // Hold an illegal request for ncyc edges; err must follow it one cycle later.
  task automatic illegal_req(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] data, input int ncyc,
                             input logic [15:0] exp_dout, input string tag);
    chk({tag, "_err_before"}, 16'(err), 16'd0);
    Rd = rd; Wr = wr; Addr = addr; DataIn = data;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk({tag, "_err"},   16'(err),   16'd1);
      chk({tag, "_stall"}, 16'(Stall), 16'd0);
    end
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    chk({tag, "_err_clear"}, 16'(err),   16'd0);
    chk({tag, "_stall2"},    16'(Stall), 16'd0);
    chk({tag, "_dout_keep"}, DataOut,    exp_dout);
  endtask

  initial begin
    int n_done;
    int n_overlap;
    int n_bad;
    int first_done;
    int second_done;

    // ---------------- reset then idle ----------------
    repeat (2) @(negedge clk);
    chk("rst_stall", 16'(Stall), 16'd0);
    chk("rst_done",  16'(Done),  16'd0);
    chk("rst_err",   16'(err),   16'd0);
    chk("rst_dout",  DataOut,    16'h0000);
    rst = 1'b1;
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Stall !== 1'b0 || Done !== 1'b0 || err !== 1'b0 || DataOut !== 16'h0000)
        n_bad++;
    end
    chk("idle_quiet_cycles", 16'(n_bad), 16'd0);

    // ---------------- write/read round trip ----------------
    run_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, "wr10");
    run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "rd10");

    // ---------------- held request and wrap ----------------
    run_req(1'b0, 1'b1, 16'h0002, 16'h1234, 16'hBEEF, "wr02");
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0802; DataIn = 16'h0000;
    @(posedge clk); // first acceptance (edge 0)
    n_done = 0; n_overlap = 0; first_done = 0; second_done = 0;
    for (int c = 1; c <= 2 * LAT + 1; c++) begin
      @(negedge clk);
      if (Stall === 1'b1 && Done === 1'b1) n_overlap++;
      if (Done === 1'b1) begin
        n_done++;
        if (n_done == 1) first_done = c;
        if (n_done == 2) second_done = c;
        chk("held_dout", DataOut, 16'h1234);
      end
    end
    Rd = 1'b0;
    chk("held_done_count",  16'(n_done),      16'd2);
    chk("held_first_done",  16'(first_done),  16'(LAT));
    chk("held_second_done", 16'(second_done), 16'(2 * LAT + 1));
    chk("held_overlap",     16'(n_overlap),   16'd0);
    @(negedge clk);
    chk("held_release_stall", 16'(Stall), 16'd0);
    chk("held_release_done",  16'(Done),  16'd0);

    // ---------------- illegal requests ----------------
    illegal_req(1'b1, 1'b1, 16'h0010, 16'h1111, 1, 16'h1234, "ill_rdwr");
    run_req(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "rd10_after_ill");
    illegal_req(1'b1, 1'b0, 16'h0003, 16'h0000, 1, 16'hBEEF, "ill_odd");
    illegal_req(1'b0, 1'b1, 16'h0005, 16'h2222, 2, 16'hBEEF, "ill_held");

    // ---------------- reset during write ----------------
    run_req(1'b0, 1'b1, 16'h0020, 16'hAAAA, 16'hBEEF, "wr20");
    Wr = 1'b1; Addr = 16'h0020; DataIn = 16'h5555;
    @(posedge clk); #1;       // edge 0: accepted
    Wr = 1'b0;
    @(negedge clk);           // cycle 1
    chk("rstw_stall_c1", 16'(Stall), 16'd1);
    @(posedge clk); #2;       // inside cycle 2
    rst = 1'b0;
    #1;
    chk("rstw_stall_async", 16'(Stall),  16'd0);
    chk("rstw_done_async",  16'(Done),   16'd0);
    chk("rstw_dout_async",  DataOut,     16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_bad = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      if (Done !== 1'b0 || Stall !== 1'b0) n_bad++;
    end
    chk("rstw_no_done", 16'(n_bad), 16'd0);
    run_req(1'b1, 1'b0, 16'h0020, 16'h0000, 16'hAAAA, "rd20_after_rst");

    // ---------------- inputs ignored while busy ----------------
    run_req(1'b0, 1'b1, 16'h0004, 16'h4444, 16'hAAAA, "wr04");
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0004; DataIn = 16'h0000;
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h0004; DataIn = 16'hFFFF;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c < LAT) begin
        chk("busyign_stall", 16'(Stall), 16'd1);
        chk("busyign_err",   16'(err),   16'd0);
      end else begin
        chk("busyign_done", 16'(Done), 16'd1);
        chk("busyign_dout", DataOut,   16'h4444);
        Wr = 1'b0;  // drop before IDLE so it is never accepted
      end
    end
    @(negedge clk);
    chk("busyign_idle_stall", 16'(Stall), 16'd0);
    run_req(1'b1, 1'b0, 16'h0004, 16'h0000, 16'h4444, "rd04_again");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
